mc_ctrl_fsm: RTL and testbench

//  Multi-cycle MIPS control unit: Moore FSM sequencing PC, memory, IR, register file,
//  ALU and the DR/A/B/ALUOut buffer registers. Decodes IR opcode/funct in DECODE.

---
 rtl/mc_ctrl_fsm_pkg.sv | 60 ++++++
 rtl/mc_ctrl_fsm_if.sv | 32 +++
 rtl/mc_ctrl_fsm_alu_decoder.sv | 27 ++
 rtl/mc_ctrl_fsm.sv | 155 +++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: state codes, opcodes,
// funct codes and datapath select/ALU control values.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11,
        StHalt   = 4'd12
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    // Control-unit internal ALU operation class fed to the ALU decoder.
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;
    localparam logic [1:0] AluOpNone  = 2'b11;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    function automatic logic funct_legal(input logic [5:0] funct);
        return (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) ||
               (funct == FnOr)  || (funct == FnSlt);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control/datapath bundle: instruction fields and flags in, enables and selects out.
interface mc_ctrl_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_we;
    logic       iord;
    logic       mem_we;
    logic       ir_we;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero,
        output pc_we, iord, mem_we, ir_we, reg_we, reg_dst, mem_to_reg, alu_src_a,
               alu_src_b, alu_ctrl, pc_src, instr_done, illegal, state
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_we, iord, mem_we, ir_we, reg_we, reg_dst, mem_to_reg, alu_src_a,
               alu_src_b, alu_ctrl, pc_src, instr_done, illegal, state
    );
endinterface

// File: rtl/mc_ctrl_fsm_alu_decoder.sv
// Maps the FSM's ALU operation class plus R-type funct onto the ALU control code.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl
);
    always_comb begin
        alu_ctrl = AluAnd;
        unique case (aluop)
            AluOpAdd: alu_ctrl = AluAdd;
            AluOpSub: alu_ctrl = AluSub;
            AluOpFunct: begin
                case (funct)
                    FnAdd:   alu_ctrl = AluAdd;
                    FnSub:   alu_ctrl = AluSub;
                    FnAnd:   alu_ctrl = AluAnd;
                    FnOr:    alu_ctrl = AluOr;
                    FnSlt:   alu_ctrl = AluSlt;
                    default: alu_ctrl = AluAdd;
                endcase
            end
            default: alu_ctrl = AluAnd;
        endcase
    end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: Moore FSM driving every datapath enable and select.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
    input logic           clk,
    input logic           rst,
    mc_ctrl_fsm_if.master bus
);
    state_e     state_q, state_d;
    logic       store_q, store_d;
    logic [1:0] aluop;
    logic [2:0] alu_ctrl;
    logic       pc_we, iord, mem_we, ir_we, reg_we, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic       instr_done, illegal;

    alu_decoder u_alu_decoder (
        .aluop    (aluop),
        .funct    (bus.funct),
        .alu_ctrl (alu_ctrl)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        aluop      = AluOpNone;
        pc_we      = 1'b0;
        iord       = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SrcBReg;
        pc_src     = PcSrcAlu;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            StFetch: begin
                ir_we     = 1'b1;
                pc_we     = 1'b1;
                alu_src_b = SrcBFour;
                aluop     = AluOpAdd;
                state_d   = StDecode;
            end
            StDecode: begin
                alu_src_b = SrcBImmSh;
                aluop     = AluOpAdd;
                // Latch lw/sw here so the opcode is not re-read in MEM_ADR.
                store_d   = (bus.opcode == OpSw);
                case (bus.opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype: begin
                        if (funct_legal(bus.funct)) state_d = StExec;
                        else                        illegal = 1'b1;
                    end
                    OpBeq:   state_d = StBranch;
                    OpAddi:  state_d = StAddiEx;
                    OpJ:     state_d = StJump;
                    default: illegal = 1'b1;
                endcase
                if (illegal) state_d = TRAP_ON_ILLEGAL ? StHalt : StFetch;
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                aluop     = AluOpAdd;
                state_d   = store_q ? StMemWr : StMemRd;
            end
            StMemRd: begin
                iord    = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                iord       = 1'b1;
                mem_we     = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StExec: begin
                alu_src_a = 1'b1;
                aluop     = AluOpFunct;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_we     = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alu_src_a  = 1'b1;
                aluop      = AluOpSub;
                pc_src     = PcSrcAluOut;
                pc_we      = bus.zero;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                aluop     = AluOpAdd;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StJump: begin
                pc_src     = PcSrcJump;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // Reset masks everything combinationally so a rising rst kills writes that cycle.
    assign bus.pc_we      = pc_we & ~rst;
    assign bus.iord       = iord & ~rst;
    assign bus.mem_we     = mem_we & ~rst;
    assign bus.ir_we      = ir_we & ~rst;
    assign bus.reg_we     = reg_we & ~rst;
    assign bus.reg_dst    = reg_dst & ~rst;
    assign bus.mem_to_reg = mem_to_reg & ~rst;
    assign bus.alu_src_a  = alu_src_a & ~rst;
    assign bus.alu_src_b  = rst ? 2'b00 : alu_src_b;
    assign bus.alu_ctrl   = rst ? 3'b000 : alu_ctrl;
    assign bus.pc_src     = rst ? 2'b00 : pc_src;
    assign bus.instr_done = instr_done & ~rst;
    assign bus.illegal    = illegal & ~rst;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: two instances (no-trap and trap-on-illegal).
module tb_mc_ctrl_fsm;
    typedef struct packed {
        logic [3:0] state;
        logic       pc_we;
        logic       iord;
        logic       mem_we;
        logic       ir_we;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       illegal;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;

    int   checks = 0;
    int   failures = 0;
    out_t q0[$];
    out_t q1[$];
    out_t act0, act1, e0, e1;

    logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [2:0] ctl_tab[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    mc_ctrl_fsm_if if0 ();
    mc_ctrl_fsm_if if1 ();

    assign if0.opcode = opcode;
    assign if0.funct  = funct;
    assign if0.zero   = zero;
    assign if1.opcode = opcode;
    assign if1.funct  = funct;
    assign if1.zero   = zero;

    mc_ctrl_fsm #(.TRAP_ON_ILLEGAL(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    mc_ctrl_fsm #(.TRAP_ON_ILLEGAL(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    assign act0 = {if0.state, if0.pc_we, if0.iord, if0.mem_we, if0.ir_we, if0.reg_we,
                   if0.reg_dst, if0.mem_to_reg, if0.alu_src_a, if0.alu_src_b, if0.alu_ctrl,
                   if0.pc_src, if0.instr_done, if0.illegal};
    assign act1 = {if1.state, if1.pc_we, if1.iord, if1.mem_we, if1.ir_we, if1.reg_we,
                   if1.reg_dst, if1.mem_to_reg, if1.alu_src_a, if1.alu_src_b, if1.alu_ctrl,
                   if1.pc_src, if1.instr_done, if1.illegal};

    always #5 clk = ~clk;

    // Hand-written per-state output table; ill/ctl/z are supplied per vector.
    function automatic out_t exp_out(input int st, input bit ill, input logic [2:0] ctl,
                                     input bit z);
        out_t e;
        e = '0;
        e.state = 4'(st);
        case (st)
            0:  begin e.ir_we = 1; e.pc_we = 1; e.alu_src_b = 2'b01; e.alu_ctrl = 3'b010; end
            1:  begin e.alu_src_b = 2'b11; e.alu_ctrl = 3'b010; e.illegal = ill; end
            2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_ctrl = 3'b010; end
            3:  e.iord = 1;
            4:  begin e.reg_we = 1; e.mem_to_reg = 1; e.instr_done = 1; end
            5:  begin e.iord = 1; e.mem_we = 1; e.instr_done = 1; end
            6:  begin e.alu_src_a = 1; e.alu_ctrl = ctl; end
            7:  begin e.reg_we = 1; e.reg_dst = 1; e.instr_done = 1; end
            8:  begin
                e.alu_src_a = 1; e.alu_ctrl = 3'b110; e.pc_src = 2'b01;
                e.pc_we = z; e.instr_done = 1;
            end
            9:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_ctrl = 3'b010; end
            10: begin e.reg_we = 1; e.instr_done = 1; end
            11: begin e.pc_src = 2'b10; e.pc_we = 1; e.instr_done = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic ex(input int st, input bit ill, input logic [2:0] ctl);
        q0.push_back(exp_out(st, ill, ctl, zero));
        q1.push_back(exp_out(st, ill, ctl, zero));
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input bit z);
        opcode = op;
        funct  = fn;
        zero   = z;
    endtask

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            q0.push_back('0);
            q1.push_back('0);
        end
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            checks++;
            if (act0 !== e0) begin
                failures++;
                $display("FAIL dut0_cycle t=%0t got=%h want=%h", $time, act0, e0);
            end
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            checks++;
            if (act1 !== e1) begin
                failures++;
                $display("FAIL dut1_cycle t=%0t got=%h want=%h", $time, act1, e1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1 do_reset(2);

        // lw: 0,1,2,3,4
        set_in(6'h23, 6'h00, 1'b0);
        ex(0, 0, 0); ex(1, 0, 0); ex(2, 0, 0); ex(3, 0, 0); ex(4, 0, 0);
        go(5);

        // beq taken and not taken
        set_in(6'h04, 6'h00, 1'b1);
        ex(0, 0, 0); ex(1, 0, 0); ex(8, 0, 0);
        go(3);
        set_in(6'h04, 6'h00, 1'b0);
        ex(0, 0, 0); ex(1, 0, 0); ex(8, 0, 0);
        go(3);

        // R-type over every supported funct
        for (int i = 0; i < 5; i++) begin
            set_in(6'h00, fn_tab[i], 1'b0);
            ex(0, 0, 0); ex(1, 0, 0); ex(6, 0, ctl_tab[i]); ex(7, 0, 0);
            go(4);
        end

        // illegal opcode: dut0 loops FETCH/DECODE, dut1 parks in HALT
        set_in(6'h3F, 6'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            q0.push_back(exp_out(0, 0, 0, 0));
            q0.push_back(exp_out(1, 1, 0, 0));
        end
        q1.push_back(exp_out(0, 0, 0, 0));
        q1.push_back(exp_out(1, 1, 0, 0));
        for (int i = 0; i < 10; i++) q1.push_back(exp_out(12, 0, 0, 0));
        go(12);
        do_reset(2);

        // illegal R funct
        set_in(6'h00, 6'h01, 1'b0);
        q0.push_back(exp_out(0, 0, 0, 0)); q0.push_back(exp_out(1, 1, 0, 0));
        q0.push_back(exp_out(0, 0, 0, 0)); q0.push_back(exp_out(1, 1, 0, 0));
        q1.push_back(exp_out(0, 0, 0, 0)); q1.push_back(exp_out(1, 1, 0, 0));
        q1.push_back(exp_out(12, 0, 0, 0)); q1.push_back(exp_out(12, 0, 0, 0));
        go(4);
        do_reset(2);

        // sw aborted by reset while in MEM_WR
        set_in(6'h2B, 6'h00, 1'b0);
        ex(0, 0, 0); ex(1, 0, 0); ex(2, 0, 0); ex(5, 0, 0);
        go(3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mem_we0", {31'd0, if0.mem_we}, 32'd0);
        chk("rst_state0", {28'd0, if0.state}, 32'd0);
        chk("rst_mem_we1", {31'd0, if1.mem_we}, 32'd0);
        @(posedge clk);
        #1 do_reset(2);

        // back-to-back sw, addi, j
        set_in(6'h2B, 6'h00, 1'b0);
        ex(0, 0, 0); ex(1, 0, 0); ex(2, 0, 0); ex(5, 0, 0);
        go(4);
        set_in(6'h08, 6'h00, 1'b0);
        ex(0, 0, 0); ex(1, 0, 0); ex(9, 0, 0); ex(10, 0, 0);
        go(4);
        set_in(6'h02, 6'h00, 1'b0);
        ex(0, 0, 0); ex(1, 0, 0); ex(11, 0, 0);
        go(3);

        @(negedge clk);
        #1;
        chk("queues_drained", q0.size() + q1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
